// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of the UART receive FIFO.
// master = FIFO side, slave = consumer that pops bytes.
interface uart_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   logic                          rd_en;
   logic [7:0]                    rd_data;
   logic                          rd_valid;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   modport master (
      input  rd_en,
      output rd_data,
      output rd_valid,
      output fifo_count
   );

   modport slave (
      output rd_en,
      input  rd_data,
      input  rd_valid,
      input  fifo_count
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchroniser, glitch-rejecting start,
// mid-bit sampling, framing check and a fall-through byte FIFO.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 12000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx,
   uart_rx_fifo_if.master   rd,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CPB  = CLK_HZ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam int AW   = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic [1:0]    sync_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          frame_err_q, frame_err_d;
   logic          busy_q, busy_d;
   logic          overrun_q, overrun_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic          rx_s;
   logic          half_end;
   logic          bit_end;
   logic          push;
   logic          pop;
   logic          wr;
   logic          empty;
   logic          full;
   logic [AW:0]   count;

   assign rx_s     = sync_q[1];
   assign half_end = (cnt_q == CW'(HALF - 1));
   assign bit_end  = (cnt_q == CW'(CPB - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CW'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      unique case (state_q)
         // synchroniser reset values stay visible for two
         // cycles, so demand three consecutive highs
         WAIT_IDLE: begin
            if (!rx_s) begin
               cnt_d = '0;
            end else if (cnt_q == CW'(2)) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (half_end) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d             = '0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d         = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_comb begin
      count     = wr_ptr_q - rd_ptr_q;
      empty     = (count == '0);
      full      = (count == (AW+1)'(FIFO_DEPTH));
      pop       = rd.rd_en && !empty;
      wr        = push && (!full || pop);
      overrun_d = push && full && !pop;
      wr_ptr_d  = wr_ptr_q + (AW+1)'(wr);
      rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q      <= 2'b11;
         state_q     <= WAIT_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b1;
         overrun_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         sync_q      <= {sync_q[0], rx};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
      end
   end

   assign rd.rd_valid   = !empty;
   assign rd.fifo_count = count;
   assign rd.rd_data    = empty ? 8'h00
                                : mem_q[rd_ptr_q[AW-1:0]];
   assign frame_err     = frame_err_q;
   assign overrun       = overrun_q;
   assign busy          = busy_q;

endmodule
